// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch slice.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/riscv_fetch_unit_if.sv
// Fetch unit bus: instruction memory request/response, redirect and decode handshake.
interface riscv_fetch_unit_if #(parameter int XLEN = riscv_pkg::XLEN);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/riscv_sync_fifo.sv
// Small synchronous FIFO with flush; DEPTH must be a power of two so pointers wrap for free.
module riscv_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != (AW+1)'(DEPTH)) || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch: sequential PC generation, credit-limited memory requests,
// response buffering toward decode, and redirect flush with stale-response killing.
module riscv_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  riscv_fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]   req_pc;
  logic [CW-1:0]     live;
  logic [CW-1:0]     kill;
  logic [CW-1:0]     out_count;
  logic [CW-1:0]     pcq_count;
  logic [XLEN-1:0]   pcq_head;
  logic [2*XLEN-1:0] out_head;
  logic [CW+1:0]     credits_used;
  logic              req_fire;
  logic              rsp_accept;
  logic              rsp_drop;
  logic              rsp_live;
  logic              rsp_keep;
  logic              out_pop;

  // Every credit term is registered, so a pop this cycle frees a slot only next cycle.
  assign credits_used       = (CW+2)'(live) + (CW+2)'(kill) + (CW+2)'(out_count);
  assign bus.imem_req_valid = !rst && !bus.redirect_valid && (credits_used < (CW+2)'(DEPTH));
  assign bus.imem_req_addr  = {req_pc[XLEN-1:2], 2'b00};
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign rsp_accept = bus.imem_rsp_valid && ((live != '0) || (kill != '0));
  assign rsp_drop   = rsp_accept && (kill != '0);
  assign rsp_live   = rsp_accept && (kill == '0);
  assign rsp_keep   = rsp_live && !bus.redirect_valid;

  assign out_pop       = bus.out_valid && bus.out_ready && !bus.redirect_valid;
  assign bus.out_valid = (out_count != '0);
  assign bus.out_pc    = out_head[2*XLEN-1:XLEN];
  assign bus.out_instr = out_head[XLEN-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pc <= RESET_PC;
      live   <= '0;
      kill   <= '0;
    end else if (bus.redirect_valid) begin
      req_pc <= bus.redirect_pc & ~XLEN'(3);
      kill   <= kill + live - CW'(rsp_accept);
      live   <= '0;
    end else begin
      if (req_fire) req_pc <= req_pc + XLEN'(4);
      if (rsp_drop) kill <= kill - 1'b1;
      if (req_fire && !rsp_live)      live <= live + 1'b1;
      else if (rsp_live && !req_fire) live <= live - 1'b1;
    end
  end

  // Stale requests stay in the PC queue until their responses drain it, so it is never flushed.
  riscv_sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (1'b0),
    .push     (req_fire),
    .push_data(req_pc),
    .pop      (rsp_accept),
    .pop_data (pcq_head),
    .count    (pcq_count)
  );

  riscv_sync_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_out_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.redirect_valid),
    .push     (rsp_keep),
    .push_data({pcq_head, bus.imem_rsp_data}),
    .pop      (out_pop),
    .pop_data (out_head),
    .count    (out_count)
  );

  rsp_protocol: assert property (@(posedge clk) disable iff (rst)
    bus.imem_rsp_valid |-> ((live != '0) || (kill != '0)));
  credit_bound: assert property (@(posedge clk) disable iff (rst)
    credits_used <= (CW+2)'(DEPTH));
  pcq_tracks_credits: assert property (@(posedge clk) disable iff (rst)
    (CW+1)'(pcq_count) == (CW+1)'(live) + (CW+1)'(kill));
endmodule
